// File: rtl/pw_mem_arbiter_if.sv
// Request/response/memory-pin bundle for the password memory arbiter.
// Latency: none (wires only). Backpressure: requesters hold valid until ready.
interface pw_mem_arbiter_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 12
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requesters and memory side.
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/pw_mem_arbiter.sv
// Round-robin two-requester sequencer for the single-port password memory; optional MEM_ARB_WR_PROTECT_EN.
// Latency: accept at A, mem_en at A+1, response at A+2+RD_LATENCY; one transaction per RD_LATENCY+3 cycles.
// Backpressure: ready only in IDLE to the granted requester; requesters hold valid/payload until ready.
module pw_mem_arbiter #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1,
    parameter int PROT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    pw_mem_arbiter_if.slave    bus
);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              blk_q;

    logic idle;
    logic gnt0;
    logic gnt1;
    logic resp0;
    logic resp1;
    logic issue;

    assign idle = (state_q == S_IDLE);
    // On a tie the requester that did not win last time gets the grant.
    assign gnt0 = idle && bus.req0_valid && (!bus.req1_valid ||  last_grant_q);
    assign gnt1 = idle && bus.req1_valid && (!bus.req0_valid || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (gnt0) begin
                    id_d         = 1'b0;
                    we_d         = bus.req0_we;
                    addr_d       = bus.req0_addr;
                    wdata_d      = bus.req0_wdata;
                    last_grant_d = 1'b0;
                    state_d      = S_ISSUE;
                end else if (gnt1) begin
                    id_d         = 1'b1;
                    we_d         = bus.req1_we;
                    addr_d       = bus.req1_addr;
                    wdata_d      = bus.req1_wdata;
                    last_grant_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // mem_rdata is valid only in the final WAIT cycle.
                if (cnt_q == CNT_LAST) begin
                    if (id_q) begin
                        rdata1_d = we_q ? '0 : bus.mem_rdata;
                    end else begin
                        rdata0_d = we_q ? '0 : bus.mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

`ifdef MEM_ARB_WR_PROTECT_EN
    logic blk_d;
    // A blocked write still walks the full sequence so its error response keeps normal timing.
    assign blk_d = idle ? (gnt1 && bus.req1_we && (bus.req1_addr < ADDR_W'(PROT_LIMIT))) : blk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= 1'b0;
        end else begin
            blk_q <= blk_d;
        end
    end
`else
    assign blk_q = 1'b0;
`endif

    assign issue = (state_q == S_ISSUE) && !blk_q;
    assign resp0 = (state_q == S_RESP) && !id_q;
    assign resp1 = (state_q == S_RESP) &&  id_q;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.mem_en     = issue;
    assign bus.mem_we     = issue && we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.rsp0_valid = resp0;
    assign bus.rsp1_valid = resp1;
    assign bus.rsp0_rdata = rdata0_q;
    assign bus.rsp1_rdata = rdata1_q;
    assign bus.rsp0_err   = 1'b0;
    assign bus.rsp1_err   = resp1 && blk_q;
    assign bus.busy       = !idle;
endmodule

// File: tb/tb_pw_mem_arbiter.sv
// Bench for pw_mem_arbiter: vector table, directed multi-cycle sequences and random traffic vs a cycle-level model.
module tb_pw_mem_arbiter;
    localparam int DW = 512;
    localparam int AW = 12;
    localparam int L  = 3;
    localparam int PL = 16;
`ifdef MEM_ARB_WR_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pw_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    pw_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(L), .PROT_LIMIT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {16{20'hA5C3E, a}};
    endfunction

    // Memory device with L-cycle read latency; non-read cycles return garbage.
    logic [DW-1:0] mem_arr [int];
    logic [DW-1:0] rd_pipe [L];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem_arr[int'(bus.mem_addr)] = bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we)
            rd_pipe[0] <= mem_arr.exists(int'(bus.mem_addr)) ? mem_arr[int'(bus.mem_addr)] : dflt(bus.mem_addr);
        else
            rd_pipe[0] <= {16{$urandom}};
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[L-1];

    // Reference model: one transaction outstanding, timed from its accept cycle.
    logic [DW-1:0] ref_mem [int];
    bit            mon_on = 1'b0;
    bit            m_act = 1'b0, m_lg = 1'b1, m_id, m_we, m_blk;
    int            m_A;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    logic [AW-1:0] x_addr = '0;
    logic [DW-1:0] x_wd = '0, x_rd0 = '0, x_rd1 = '0;
    int            grant_log [$];

    always @(negedge clk) begin : monitor
        bit v0, v1, er0, er1, een, ers0, ers1;
        int c;
        if (mon_on) begin
            c  = cyc;
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
            er0 = !m_act && v0 && (!v1 ||  m_lg);
            er1 = !m_act && v1 && (!v0 || !m_lg);
            if (m_act && c == m_A + 1) begin
                m_rd = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : dflt(m_addr);
                if (m_we && !m_blk) ref_mem[int'(m_addr)] = m_wd;
            end
            een  = m_act && (c == m_A + 1) && !m_blk;
            ers0 = m_act && (c == m_A + 2 + L) && !m_id;
            ers1 = m_act && (c == m_A + 2 + L) &&  m_id;
            if (ers0) x_rd0 = m_we ? '0 : m_rd;
            if (ers1) x_rd1 = m_we ? '0 : m_rd;
            chk("req0_ready", bus.req0_ready, er0);
            chk("req1_ready", bus.req1_ready, er1);
            chk("busy",       bus.busy,       m_act);
            chk("mem_en",     bus.mem_en,     een);
            chk("mem_we",     bus.mem_we,     een && m_we);
            chk("mem_addr",   bus.mem_addr,   x_addr);
            chk("mem_wdata",  bus.mem_wdata,  x_wd);
            chk("rsp0_valid", bus.rsp0_valid, ers0);
            chk("rsp1_valid", bus.rsp1_valid, ers1);
            chk("rsp0_rdata", bus.rsp0_rdata, x_rd0);
            chk("rsp1_rdata", bus.rsp1_rdata, x_rd1);
            chk("rsp0_err",   bus.rsp0_err,   1'b0);
            chk("rsp1_err",   bus.rsp1_err,   ers1 && m_blk);
            if (rst) begin
                m_act = 1'b0; m_lg = 1'b1;
                x_addr = '0; x_wd = '0; x_rd0 = '0; x_rd1 = '0;
            end else begin
                if (m_act && c == m_A + 2 + L) m_act = 1'b0;
                if (er0 || er1) begin
                    m_act  = 1'b1;
                    m_A    = c;
                    m_id   = er1;
                    m_we   = er1 ? bus.req1_we    : bus.req0_we;
                    m_addr = er1 ? bus.req1_addr  : bus.req0_addr;
                    m_wd   = er1 ? bus.req1_wdata : bus.req0_wdata;
                    m_blk  = PROT && er1 && m_we && (int'(m_addr) < PL);
                    m_lg   = er1;
                    x_addr = m_addr;
                    x_wd   = m_wd;
                    grant_log.push_back(int'(er1));
                end
            end
        end
    end

    task automatic drive(input int id, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = wd;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = wd;
        end
    endtask

    task automatic issue_req(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             output int acc, output bit ok);
        bit got = 1'b0;
        acc = -1;
        @(posedge clk); #1;
        drive(id, 1'b1, we, a, wd);
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if ((id == 0) ? bus.req0_ready : bus.req1_ready) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        @(posedge clk); #1;
        drive(id, 1'b0, we, a, wd);
        chk("accept_seen", got, 1'b1);
        ok = got;
    endtask

    task automatic do_req(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output bit err);
        int acc, rc;
        bit ok;
        bit got = 1'b0;
        rd = '0; err = 1'b0; rc = 0;
        issue_req(id, we, a, wd, acc, ok);
        if (ok) begin
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if ((id == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
                    got = 1'b1;
                    rc  = cyc;
                    rd  = (id == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
                    err = (id == 0) ? bus.rsp0_err   : bus.rsp1_err;
                end
            end
            chk("rsp_seen", got, 1'b1);
            if (got) chk("rsp_latency", DW'(rc - acc), DW'(L + 2));
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic rand_driver(input int id, input int n);
        logic [DW-1:0] wd, rd;
        logic [AW-1:0] a;
        bit err;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            for (int j = 0; j < 16; j++) wd[j*32 +: 32] = $urandom;
            a = ($urandom_range(0, 7) == 0) ? 12'hFFF : AW'($urandom_range(0, 31));
            do_req(id, bit'($urandom_range(0, 1)), a, wd, rd, err);
        end
    endtask

    typedef struct {
        int            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion within time limit, want finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        vec_t          tv [12];
        logic [DW-1:0] rd, ones;
        bit            err, ok;
        int            acc, seen;
        int            acc_t [6];

        ones = '1;
        tv[0]  = '{0, 1'b0, 12'h005, '0,               DW'(32'h4675636b), 1'b0};
        tv[1]  = '{1, 1'b1, 12'h010, DW'(32'h59656574), '0,               1'b0};
        tv[2]  = '{1, 1'b0, 12'h010, '0,               DW'(32'h59656574), 1'b0};
        tv[3]  = '{0, 1'b1, 12'h008, DW'(16'h1234),    '0,               1'b0};
        tv[4]  = '{1, 1'b1, 12'h008, DW'(16'hbeef),    '0,               PROT};
        tv[5]  = '{0, 1'b0, 12'h008, '0,               PROT ? DW'(16'h1234) : DW'(16'hbeef), 1'b0};
        tv[6]  = '{1, 1'b0, 12'h008, '0,               PROT ? DW'(16'h1234) : DW'(16'hbeef), 1'b0};
        tv[7]  = '{0, 1'b0, 12'hFFF, '0,               {16{32'hA5C3EFFF}}, 1'b0};
        tv[8]  = '{1, 1'b1, 12'hFFF, ones,             '0,               1'b0};
        tv[9]  = '{0, 1'b0, 12'hFFF, '0,               ones,             1'b0};
        tv[10] = '{1, 1'b1, 12'h00F, DW'(8'h77),       '0,               PROT};
        tv[11] = '{0, 1'b0, 12'h00F, '0,               PROT ? {16{32'hA5C3E00F}} : DW'(8'h77), 1'b0};

        mem_arr[5] = DW'(32'h4675636b);
        ref_mem[5] = DW'(32'h4675636b);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        @(posedge clk); #1 mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",     bus.busy,       1'b0);
        chk("reset_mem_en",   bus.mem_en,     1'b0);
        chk("reset_mem_addr", bus.mem_addr,   '0);
        chk("reset_mem_wdata", bus.mem_wdata, '0);
        chk("reset_rsp0",     bus.rsp0_valid, 1'b0);
        chk("reset_rdata1",   bus.rsp1_rdata, '0);

        for (int i = 0; i < 12; i++) begin
            do_req(tv[i].id, tv[i].we, tv[i].addr, tv[i].wd, rd, err);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
            chk($sformatf("vec%0d_err", i), err, tv[i].exp_err);
        end

        // Both requesters contend from reset: strict alternation starting with 0.
        pulse_rst();
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) do_req(0, 1'b0, AW'(12'h020 + k), '0, rd, err);
            end
            begin
                logic [DW-1:0] rd1;
                bit            err1;
                for (int k = 0; k < 4; k++) do_req(1, 1'b1, AW'(12'h020 + k), DW'(32'hC0DE0000 + k), rd1, err1);
            end
        join
        for (int k = 0; k < 8; k++)
            chk("grant_order", (k < grant_log.size()) ? DW'(grant_log[k]) : DW'(9), DW'(k % 2));

        // Continuous requester 0: accepts spaced by L+3 cycles.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 12'h100, '0);
        for (int n = 0; n < 6; n++) begin
            ok = 1'b0;
            acc_t[n] = 0;
            for (int k = 0; k < 30 && !ok; k++) begin
                @(negedge clk);
                if (bus.req0_ready) begin
                    ok = 1'b1;
                    acc_t[n] = cyc;
                end
            end
            chk("stream_accept", ok, 1'b1);
            @(posedge clk); #1;
            drive(0, n < 5, 1'b0, AW'(12'h101 + n), '0);
        end
        for (int n = 1; n < 6; n++) chk("stream_period", DW'(acc_t[n] - acc_t[n-1]), DW'(L + 3));
        repeat (L + 4) @(posedge clk);

        // Reset during WAIT of a requester-1 read drops it.
        do_req(0, 1'b0, 12'h004, '0, rd, err);
        issue_req(1, 1'b0, 12'h003, '0, acc, ok);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",     bus.busy,       1'b0);
        chk("rst_mem_en",   bus.mem_en,     1'b0);
        chk("rst_mem_addr", bus.mem_addr,   '0);
        chk("rst_rdata0",   bus.rsp0_rdata, '0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rsp1_valid) seen++;
        end
        chk("rst_no_rsp1", DW'(seen), '0);
        grant_log.delete();
        fork
            do_req(0, 1'b0, 12'h001, '0, rd, err);
            begin
                logic [DW-1:0] rd1;
                bit            err1;
                do_req(1, 1'b0, 12'h002, '0, rd1, err1);
            end
        join
        chk("rst_first_grant", (grant_log.size() > 0) ? DW'(grant_log[0]) : DW'(9), '0);

        // Last winner was 0; reset must restore priority to requester 0.
        do_req(0, 1'b0, 12'h006, '0, rd, err);
        pulse_rst();
        grant_log.delete();
        fork
            do_req(0, 1'b0, 12'h007, '0, rd, err);
            begin
                logic [DW-1:0] rd1;
                bit            err1;
                do_req(1, 1'b0, 12'h009, '0, rd1, err1);
            end
        join
        chk("lg_reset_grant", (grant_log.size() > 0) ? DW'(grant_log[0]) : DW'(9), '0);

        fork
            rand_driver(0, 25);
            rand_driver(1, 25);
        join
        repeat (L + 6) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
